// File: rtl/hs_npu_array_ctrl.sv
// Control sequencer for a weight-stationary systolic MAC array: weight load, activation
// streaming and drain, with a valid/last strobe aligned to each result leaving the array.
module hs_npu_array_ctrl #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int EXTRA_LAT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  output logic             arr_w_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             arr_a_valid,
  output logic             out_valid,
  output logic             out_last
);

  localparam int LAT  = ROWS + COLS + EXTRA_LAT;
  localparam int WC_W = $clog2(ROWS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r;
  logic [WC_W-1:0]  w_cnt_r;
  logic [CNT_W-1:0] nv_r;
  logic [CNT_W-1:0] issued_r;
  logic [CNT_W-1:0] emitted_r;
  logic [LAT-1:0]   vsr_r;
  logic             busy_r;
  logic             done_r;
  logic             w_ready_r;
  logic             in_ready_r;

  logic             w_acc_s;
  logic             a_acc_s;
  logic             last_w_s;
  logic             last_a_s;
  logic             drain_empty_s;
  logic [CNT_W-1:0] emitted_next_s;

  assign w_acc_s  = w_valid & w_ready_r;
  assign a_acc_s  = in_valid & in_ready_r;
  assign last_w_s = (w_cnt_r == WC_W'(ROWS - 1));
  assign last_a_s = (issued_r == (nv_r - {{(CNT_W-1){1'b0}}, 1'b1}));

  // Exit DRAIN in the cycle the final result is on the output, so done follows out_last directly.
  assign emitted_next_s = emitted_r + {{(CNT_W-1){1'b0}}, vsr_r[LAT-1]};
  assign drain_empty_s  = (vsr_r[LAT-2:0] == '0) && (emitted_next_s == issued_r);

  assign busy        = busy_r;
  assign done        = done_r;
  assign w_ready     = w_ready_r;
  assign in_ready    = in_ready_r;
  assign arr_w_en    = w_acc_s;
  assign arr_a_valid = a_acc_s;
  assign out_valid   = vsr_r[LAT-1];
  assign out_last    = vsr_r[LAT-1] && (emitted_r == (nv_r - {{(CNT_W-1){1'b0}}, 1'b1}));

  // Job sequencer, per-job counters and the result-valid delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      w_cnt_r    <= '0;
      nv_r       <= '0;
      issued_r   <= '0;
      emitted_r  <= '0;
      vsr_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      w_ready_r  <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      vsr_r     <= {vsr_r[LAT-2:0], a_acc_s};
      emitted_r <= emitted_next_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= LOAD_W;
            nv_r      <= num_vecs;
            w_cnt_r   <= '0;
            issued_r  <= '0;
            emitted_r <= '0;
            busy_r    <= 1'b1;
            w_ready_r <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        LOAD_W: begin
          if (w_acc_s) begin
            if (last_w_s) begin
              w_ready_r <= 1'b0;
              if (nv_r == '0) begin
                state_r <= DRAIN;
              end else begin
                state_r    <= STREAM;
                in_ready_r <= 1'b1;
              end
            end else begin
              w_cnt_r <= w_cnt_r + {{(WC_W-1){1'b0}}, 1'b1};
            end
          end
        end
        STREAM: begin
          if (a_acc_s) begin
            issued_r <= issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_a_s) begin
              in_ready_r <= 1'b0;
              state_r    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_empty_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          w_ready_r  <= 1'b0;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_npu_array_ctrl.sv
// Randomized bench for hs_npu_array_ctrl (ROWS=COLS=4, LAT=8) against a job-level timing model.
module tb_hs_npu_array_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 16;
  localparam int LAT   = 8;
  localparam int NCYC  = 8192;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vecs = '0;
  logic             w_valid = 1'b0;
  logic             in_valid = 1'b0;
  logic             busy, done, w_ready, arr_w_en, in_ready, arr_a_valid, out_valid, out_last;

  hs_npu_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .EXTRA_LAT(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .arr_w_en(arr_w_en), .in_valid(in_valid),
    .in_ready(in_ready), .arr_a_valid(arr_a_valid), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Job model: remaining weights/vectors, plus an absolute-cycle schedule of expected results.
  bit m_busy = 1'b0;
  int m_wleft = 0;
  int m_vleft = 0;
  int m_nv = 0;
  int m_done = -1;
  bit sched_v[NCYC];
  bit sched_l[NCYC];

  // 0 random(prob), 1 always, 2 alternate, 3 one-in-three, other never
  int w_mode = 1;
  int i_mode = 1;
  int w_prob = 100;
  int i_prob = 100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit pick(input int mode, input int prob);
    case (mode)
      0: return ($urandom_range(0, 99) < prob);
      1: return 1'b1;
      2: return (cyc % 2 == 0);
      3: return (cyc % 3 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    bit we, ie, wen, aen, ov;
    w_valid  = pick(w_mode, w_prob);
    in_valid = pick(i_mode, i_prob);
    #1;
    we  = m_busy && (m_wleft > 0);
    ie  = m_busy && (m_wleft == 0) && (m_vleft > 0);
    wen = we && w_valid;
    aen = ie && in_valid;
    ov  = sched_v[cyc];
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, (cyc == m_done));
      chk("w_ready", w_ready, we);
      chk("in_ready", in_ready, ie);
      chk("arr_w_en", arr_w_en, wen);
      chk("arr_a_valid", arr_a_valid, aen);
      chk("out_valid", out_valid, ov);
      chk("out_last", out_last, ov && sched_l[cyc]);
    end
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_wleft = 0;
      m_vleft = 0;
      m_done  = -1;
      for (int k = cyc + 1; k <= cyc + LAT; k++) begin
        sched_v[k] = 1'b0;
        sched_l[k] = 1'b0;
      end
    end else if (!m_busy) begin
      if (start) begin
        m_busy  = 1'b1;
        m_wleft = ROWS;
        m_nv    = int'(num_vecs);
        m_vleft = m_nv;
      end
    end else begin
      if (wen) begin
        m_wleft--;
        if (m_wleft == 0 && m_nv == 0) m_done = cyc + 2;
      end
      if (aen) begin
        sched_v[cyc + LAT] = 1'b1;
        sched_l[cyc + LAT] = (m_vleft == 1);
        m_vleft--;
        if (m_vleft == 0) m_done = cyc + LAT + 1;
      end
      if (cyc == m_done) begin
        m_busy = 1'b0;
        m_done = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic job(input int n);
    num_vecs = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (m_busy && k < limit) begin
      tick();
      k++;
    end
    chk("job_timeout", m_busy, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      sched_v[k] = 1'b0;
      sched_l[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // basic job
    w_mode = 1; i_mode = 1;
    job(3);
    wait_idle(100);

    // stalled weights and gapped activations
    w_mode = 2; i_mode = 3;
    job(5);
    wait_idle(100);

    // empty job
    w_mode = 1; i_mode = 1;
    job(0);
    wait_idle(50);

    // start held through a job with a new count, then re-accepted right after done
    num_vecs = CNT_W'(3);
    start = 1'b1;
    tick();
    num_vecs = CNT_W'(9);
    begin
      int k = 0;
      while (m_busy && k < 100) begin
        tick();
        k++;
      end
    end
    tick();
    start = 1'b0;
    wait_idle(100);

    // reset during drain
    job(3);
    begin
      int k = 0;
      while (!(m_busy && m_wleft == 0 && m_vleft == 0) && k < 100) begin
        tick();
        k++;
      end
    end
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    job(2);
    wait_idle(100);

    // single vector arriving late
    w_mode = 1; i_mode = 4;
    job(1);
    repeat (24) tick();
    i_mode = 1;
    wait_idle(100);

    // random jobs with random stalls
    w_mode = 0; i_mode = 0;
    repeat (20) begin
      w_prob = $urandom_range(30, 100);
      i_prob = $urandom_range(30, 100);
      job($urandom_range(0, 7));
      wait_idle(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
